// File: rtl/alarm_if.sv
// Signal bundle between the time/keypad side and the alarm unit.
// The master drives time digits, alarm programming and user buttons; the slave returns alarm state.
interface alarm_if;
  logic [3:0] sec_o, sec_t, min_o, min_t, hr_o, hr_t;
  logic [3:0] al_in_m_o, al_in_m_t, al_in_h_o, al_in_h_t;
  logic       alarm_set;
  logic       alarm_en;
  logic       stop;
  logic       snooze;
  logic [3:0] al_m_o, al_m_t, al_h_o, al_h_t;
  logic       alarm_ring;
  logic       snooze_active;
  logic [2:0] snoozes_left;
  logic       set_err;

  modport master (
    output sec_o, sec_t, min_o, min_t, hr_o, hr_t,
    output al_in_m_o, al_in_m_t, al_in_h_o, al_in_h_t,
    output alarm_set, alarm_en, stop, snooze,
    input  al_m_o, al_m_t, al_h_o, al_h_t,
    input  alarm_ring, snooze_active, snoozes_left, set_err
  );

  modport slave (
    input  sec_o, sec_t, min_o, min_t, hr_o, hr_t,
    input  al_in_m_o, al_in_m_t, al_in_h_o, al_in_h_t,
    input  alarm_set, alarm_en, stop, snooze,
    output al_m_o, al_m_t, al_h_o, al_h_t,
    output alarm_ring, snooze_active, snoozes_left, set_err
  );
endinterface

// File: rtl/alarm_unit.sv
// Alarm clock controller: stores an HH:MM alarm, rings on match with bounded duration,
// and supports a limited number of fixed-length snoozes. One clock cycle is one second.
module alarm_unit #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MIN  = 5,
  parameter int MAX_SNOOZES = 3
) (
  input logic    clk_1hz,
  input logic    rst,
  alarm_if.slave bus
);

  localparam int SNZ_CYC = SNOOZE_MIN * 60;
  localparam int RC_W    = $clog2(RING_SECS);
  localparam int SZ_W    = $clog2(SNZ_CYC);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  state_t            r_state, w_state_nxt;
  logic [RC_W-1:0]   r_ring_cnt, w_ring_cnt_nxt;
  logic [SZ_W-1:0]   r_snz_cnt, w_snz_cnt_nxt;
  logic [2:0]        r_left, w_left_nxt;
  logic [15:0]       r_al, w_al_nxt;
  logic              r_err, w_err_nxt;
  logic              w_set_ok;
  logic              w_match;

  assign w_set_ok = (bus.al_in_h_t <= 4'd2) &&
                    ((bus.al_in_h_t == 4'd2) ? (bus.al_in_h_o <= 4'd3) : (bus.al_in_h_o <= 4'd9)) &&
                    (bus.al_in_m_t <= 4'd5) && (bus.al_in_m_o <= 4'd9);

  // r_al packs the stored alarm as {h_t, h_o, m_t, m_o}
  assign w_match = ({bus.hr_t, bus.hr_o, bus.min_t, bus.min_o} == r_al) &&
                   (bus.sec_t == 4'd0) && (bus.sec_o == 4'd0);

  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_left     <= 3'(MAX_SNOOZES);
      r_al       <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_left     <= w_left_nxt;
      r_al       <= w_al_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_cnt_nxt  = r_snz_cnt;
    w_left_nxt     = r_left;
    w_al_nxt       = r_al;
    w_err_nxt      = 1'b0;
    if (bus.alarm_set) begin
      // A rejected set leaves the whole machine frozen for this edge
      if (w_set_ok) begin
        w_al_nxt    = {bus.al_in_h_t, bus.al_in_h_o, bus.al_in_m_t, bus.al_in_m_o};
        w_state_nxt = IDLE;
        w_left_nxt  = 3'(MAX_SNOOZES);
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (!bus.alarm_en) begin
      w_state_nxt = IDLE;
      w_left_nxt  = 3'(MAX_SNOOZES);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_match) begin
            w_state_nxt    = RINGING;
            w_ring_cnt_nxt = '0;
          end
        end
        RINGING: begin
          w_ring_cnt_nxt = r_ring_cnt + 1'b1;
          if (bus.stop) begin
            w_state_nxt = IDLE;
            w_left_nxt  = 3'(MAX_SNOOZES);
          end else if (bus.snooze && (r_left != 3'd0)) begin
            w_state_nxt   = SNOOZE;
            w_snz_cnt_nxt = SZ_W'(SNZ_CYC - 1);
            w_left_nxt    = r_left - 3'd1;
          end else if (r_ring_cnt == RC_W'(RING_SECS - 1)) begin
            w_state_nxt = IDLE;
            w_left_nxt  = 3'(MAX_SNOOZES);
          end
        end
        SNOOZE: begin
          w_snz_cnt_nxt = r_snz_cnt - 1'b1;
          if (bus.stop) begin
            w_state_nxt = IDLE;
            w_left_nxt  = 3'(MAX_SNOOZES);
          end else if (r_snz_cnt == '0) begin
            w_state_nxt    = RINGING;
            w_ring_cnt_nxt = '0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.al_h_t        = r_al[15:12];
  assign bus.al_h_o        = r_al[11:8];
  assign bus.al_m_t        = r_al[7:4];
  assign bus.al_m_o        = r_al[3:0];
  assign bus.alarm_ring    = (r_state == RINGING);
  assign bus.snooze_active = (r_state == SNOOZE);
  assign bus.snoozes_left  = r_left;
  assign bus.set_err       = r_err;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit with short ring (5 s), 1-minute snooze and a 2-snooze budget.
module tb_alarm_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alarm_if u_if ();

  alarm_unit #(
    .RING_SECS  (5),
    .SNOOZE_MIN (1),
    .MAX_SNOOZES(2)
  ) dut (
    .clk_1hz(clk),
    .rst    (rst),
    .bus    (u_if.slave)
  );

  typedef struct {
    string       tag;
    logic [21:0] v;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic set_time(input int h, input int m, input int s);
    u_if.hr_t  = 4'(h / 10);
    u_if.hr_o  = 4'(h % 10);
    u_if.min_t = 4'(m / 10);
    u_if.min_o = 4'(m % 10);
    u_if.sec_t = 4'(s / 10);
    u_if.sec_o = 4'(s % 10);
  endtask

  task automatic prog(input int h, input int m);
    u_if.al_in_h_t = 4'(h / 10);
    u_if.al_in_h_o = 4'(h % 10);
    u_if.al_in_m_t = 4'(m / 10);
    u_if.al_in_m_o = 4'(m % 10);
  endtask

  // Push expected outputs for this edge, clock once, then pop and compare
  task automatic step(input string tag, input logic ring, input logic snza,
                      input logic [2:0] left, input logic err, input logic [15:0] al);
    exp_t e;
    logic [21:0] obs;
    sbq.push_back('{tag: tag, v: {ring, snza, left, err, al}});
    @(posedge clk);
    #1;
    obs = {u_if.alarm_ring, u_if.snooze_active, u_if.snoozes_left, u_if.set_err,
           u_if.al_h_t, u_if.al_h_o, u_if.al_m_t, u_if.al_m_o};
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s got ring/snz/left/err/al=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    u_if.alarm_set = 1'b0;
    u_if.alarm_en  = 1'b0;
    u_if.stop      = 1'b0;
    u_if.snooze    = 1'b0;
    set_time(0, 0, 0);
    prog(0, 0);

    step("rst0", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0000);
    step("rst1", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0000);

    rst = 1'b0;
    u_if.alarm_en = 1'b1;
    step("match_0000", 1'b1, 1'b0, 3'd2, 1'b0, 16'h0000);
    set_time(0, 0, 1);
    u_if.stop = 1'b1;
    step("stop_0000", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0000);
    u_if.stop = 1'b0;

    set_time(7, 29, 59);
    prog(7, 30);
    u_if.alarm_set = 1'b1;
    step("set_0730", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0730);
    u_if.alarm_set = 1'b0;
    step("no_ring_072959", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0730);
    set_time(7, 30, 0);
    step("ring_073000", 1'b1, 1'b0, 3'd2, 1'b0, 16'h0730);
    set_time(7, 30, 1);
    for (int i = 0; i < 4; i++) step("ring_hold", 1'b1, 1'b0, 3'd2, 1'b0, 16'h0730);
    step("auto_off", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0730);
    step("no_rematch", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0730);

    prog(24, 0);
    u_if.alarm_set = 1'b1;
    step("bad_2400", 1'b0, 1'b0, 3'd2, 1'b1, 16'h0730);
    u_if.alarm_set = 1'b0;
    step("err_clear1", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0730);
    u_if.al_in_h_t = 4'd1; u_if.al_in_h_o = 4'd2;
    u_if.al_in_m_t = 4'd6; u_if.al_in_m_o = 4'd0;
    u_if.alarm_set = 1'b1;
    step("bad_1260", 1'b0, 1'b0, 3'd2, 1'b1, 16'h0730);
    u_if.alarm_set = 1'b0;
    step("err_clear2", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0730);

    set_time(7, 30, 0);
    step("trig_snz", 1'b1, 1'b0, 3'd2, 1'b0, 16'h0730);
    set_time(7, 30, 1);
    u_if.snooze = 1'b1;
    step("snooze1", 1'b0, 1'b1, 3'd1, 1'b0, 16'h0730);
    u_if.snooze = 1'b0;
    for (int i = 0; i < 59; i++) step("snz1_off", 1'b0, 1'b1, 3'd1, 1'b0, 16'h0730);
    step("re_ring1", 1'b1, 1'b0, 3'd1, 1'b0, 16'h0730);
    u_if.snooze = 1'b1;
    step("snooze2", 1'b0, 1'b1, 3'd0, 1'b0, 16'h0730);
    u_if.snooze = 1'b0;
    for (int i = 0; i < 59; i++) step("snz2_off", 1'b0, 1'b1, 3'd0, 1'b0, 16'h0730);
    step("re_ring2", 1'b1, 1'b0, 3'd0, 1'b0, 16'h0730);
    u_if.snooze = 1'b1;
    step("snooze3_ignored", 1'b1, 1'b0, 3'd0, 1'b0, 16'h0730);
    u_if.stop = 1'b1;
    step("stop_over_snooze", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0730);
    u_if.stop = 1'b0;
    u_if.snooze = 1'b0;

    set_time(7, 30, 0);
    step("trig_en", 1'b1, 1'b0, 3'd2, 1'b0, 16'h0730);
    set_time(7, 30, 1);
    u_if.snooze = 1'b1;
    step("snooze_en", 1'b0, 1'b1, 3'd1, 1'b0, 16'h0730);
    u_if.snooze = 1'b0;
    u_if.alarm_en = 1'b0;
    step("disable_in_snz", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0730);
    u_if.alarm_en = 1'b1;

    set_time(7, 30, 0);
    step("trig_rst", 1'b1, 1'b0, 3'd2, 1'b0, 16'h0730);
    set_time(7, 30, 1);
    rst = 1'b1;
    step("rst_mid_ring", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0000);
    rst = 1'b0;
    step("after_rst", 1'b0, 1'b0, 3'd2, 1'b0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
